vec_mem_seq_unit: RTL and testbench

//  Parametrised vector load/store sequencer between the vector datapath and the

---
 rtl/vec_mem_seq_unit.sv | 153 +++++++++++++++
 tb/tb_vec_mem_seq_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_seq_unit.sv
// rtl/vec_mem_seq_unit.sv - vector load/store sequencer to a word-wide RAM
// Serialises a LANES-word vector into strided single-word accesses and gathers loads back.
module vec_mem_seq_unit #(
    parameter int LANES  = 2,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W-1:0]         stride,
    input  logic [LANES*WORD_W-1:0]   vec_data_in,
    input  logic [WORD_W-1:0]         mem_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [WORD_W-1:0]         mem_wdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [LANES*WORD_W-1:0]   vec_data_out,
    output logic                      busy,
    output logic                      done
);

    localparam int CW = $clog2(LANES + 1);
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             lane_q, lane_d, lane_nxt;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [ADDR_W-1:0]         stride_q, stride_d;
    logic                      we_q, we_d;
    logic                      en_q, en_d;
    logic [WORD_W-1:0]         wdata_q, wdata_d;
    logic [LANES*WORD_W-1:0]   vec_q, vec_d;
    logic [LANES*WORD_W-1:0]   vout_q, vout_d;

    // Read tag pipeline: entry RD_LAT-1 names the lane whose data is on mem_rdata now.
    logic [RD_LAT-1:0]         pv_q;
    logic [CW-1:0]             pl_q [RD_LAT];
    logic                      cap_v;
    logic [CW-1:0]             cap_lane;

    assign cap_v    = pv_q[RD_LAT-1];
    assign cap_lane = pl_q[RD_LAT-1];
    assign lane_nxt = lane_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        we_d     = we_q;
        en_d     = en_q;
        wdata_d  = wdata_q;
        vec_d    = vec_q;
        vout_d   = vout_q;
        if (cap_v) begin
            vout_d[int'(cap_lane)*WORD_W +: WORD_W] = mem_rdata;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ISSUE;
                    lane_d   = '0;
                    addr_d   = base_addr;
                    stride_d = stride;
                    we_d     = wr_en;
                    vec_d    = vec_data_in;
                    en_d     = 1'b1;
                    if (wr_en) begin
                        wdata_d = vec_data_in[WORD_W-1:0];
                    end
                end
            end
            S_ISSUE: begin
                if (lane_q == LAST) begin
                    en_d    = 1'b0;
                    state_d = we_q ? S_DONE : S_DRAIN;
                end else begin
                    lane_d = lane_nxt;
                    addr_d = addr_q + stride_q;
                    if (we_q) begin
                        wdata_d = vec_q[int'(lane_nxt)*WORD_W +: WORD_W];
                    end
                end
            end
            S_DRAIN: begin
                if (cap_v && cap_lane == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            lane_q   <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            we_q     <= 1'b0;
            en_q     <= 1'b0;
            wdata_q  <= '0;
            vec_q    <= '0;
            vout_q   <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            we_q     <= we_d;
            en_q     <= en_d;
            wdata_q  <= wdata_d;
            vec_q    <= vec_d;
            vout_q   <= vout_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pl_q[k] <= '0;
            end
        end else begin
            pv_q[0] <= en_q & ~we_q;
            pl_q[0] <= lane_q;
            for (int k = 1; k < RD_LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                pl_q[k] <= pl_q[k-1];
            end
        end
    end

    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_en       = en_q;
    assign mem_we       = en_q & we_q;
    assign vec_data_out = vout_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_vec_mem_seq_unit.sv
// tb/tb_vec_mem_seq_unit.sv - directed self-checking bench for vec_mem_seq_unit
// Two instances: A (LANES=2, RD_LAT=1) and B (LANES=4, RD_LAT=3), each with a RAM model.
module tb_vec_mem_seq_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         preload;

    logic         start_a, wr_a, en_a, we_a, busy_a, done_a;
    logic [31:0]  base_a, stride_a, rdata_a, addr_a, wdata_a;
    logic [63:0]  vin_a, vout_a;

    logic         start_b, wr_b, en_b, we_b, busy_b, done_b;
    logic [31:0]  base_b, stride_b, rdata_b, addr_b, wdata_b;
    logic [127:0] vin_b, vout_b;

    logic [31:0]  ram_a [256];
    logic [31:0]  ram_b [256];
    logic [31:0]  rp_b  [3];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt_a = 0;
    int en_cnt_a   = 0;
    int dc0, ec0;

    always #5 clk = ~clk;

    vec_mem_seq_unit #(.LANES(2), .WORD_W(32), .ADDR_W(32), .RD_LAT(1)) u_a (
        .clk(clk), .reset(rst_n), .start(start_a), .wr_en(wr_a),
        .base_addr(base_a), .stride(stride_a), .vec_data_in(vin_a),
        .mem_rdata(rdata_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .mem_en(en_a), .mem_we(we_a), .vec_data_out(vout_a),
        .busy(busy_a), .done(done_a)
    );

    vec_mem_seq_unit #(.LANES(4), .WORD_W(32), .ADDR_W(32), .RD_LAT(3)) u_b (
        .clk(clk), .reset(rst_n), .start(start_b), .wr_en(wr_b),
        .base_addr(base_b), .stride(stride_b), .vec_data_in(vin_b),
        .mem_rdata(rdata_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .mem_en(en_b), .mem_we(we_b), .vec_data_out(vout_b),
        .busy(busy_b), .done(done_b)
    );

    // RAM A: one-cycle read latency
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) ram_a[k] <= 32'hA000_0000 | k;
        end else if (en_a && we_a) begin
            ram_a[addr_a[7:0]] <= wdata_a;
        end
        rdata_a <= ram_a[addr_a[7:0]];
    end

    // RAM B: three-cycle read latency
    assign rdata_b = rp_b[2];
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) ram_b[k] <= 32'hB000_0000 | k;
        end else if (en_b && we_b) begin
            ram_b[addr_b[7:0]] <= wdata_b;
        end
        rp_b[0] <= ram_b[addr_b[7:0]];
        rp_b[1] <= rp_b[0];
        rp_b[2] <= rp_b[1];
    end

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (en_a)   en_cnt_a++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; preload = 1'b1;
        start_a = 0; wr_a = 0; base_a = 0; stride_a = 0; vin_a = '0;
        start_b = 0; wr_b = 0; base_b = 0; stride_b = 0; vin_b = '0;
        repeat (2) tick();
        chk("rst_en_a",   en_a,   0);
        chk("rst_addr_a", addr_a, 0);
        chk("rst_wd_a",   wdata_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_vout_b", vout_b, 0);
        preload = 1'b0; rst_n = 1'b1;
        tick();

        // Test 1: store on A
        start_a = 1; wr_a = 1; base_a = 32'h10; stride_a = 1;
        vin_a = {32'hBBBB, 32'hAAAA};
        tick();                                   // T+1
        start_a = 0; vin_a = '1;
        chk("t1_en0",   en_a, 1);
        chk("t1_we0",   we_a, 1);
        chk("t1_addr0", addr_a, 32'h10);
        chk("t1_wd0",   wdata_a, 32'hAAAA);
        chk("t1_busy",  busy_a, 1);
        tick();                                   // T+2
        chk("t1_addr1", addr_a, 32'h11);
        chk("t1_wd1",   wdata_a, 32'hBBBB);
        chk("t1_en1",   en_a, 1);
        tick();                                   // T+3
        chk("t1_en_off", en_a, 0);
        chk("t1_we_off", we_a, 0);
        chk("t1_done",   done_a, 1);
        chk("t1_vout",   vout_a, 0);
        tick();                                   // T+4
        chk("t1_done_off", done_a, 0);
        chk("t1_idle",     busy_a, 0);
        chk("t1_ram10", ram_a[8'h10], 32'hAAAA);
        chk("t1_ram11", ram_a[8'h11], 32'hBBBB);

        // Test 2: load back on A
        start_a = 1; wr_a = 0; base_a = 32'h10; stride_a = 1;
        tick();                                   // T+1
        start_a = 0;
        chk("t2_en0",   en_a, 1);
        chk("t2_we0",   we_a, 0);
        chk("t2_addr0", addr_a, 32'h10);
        chk("t2_wd_hold", wdata_a, 32'hBBBB);
        tick();                                   // T+2
        chk("t2_addr1", addr_a, 32'h11);
        tick();                                   // T+3
        chk("t2_en_off", en_a, 0);
        chk("t2_busy",   busy_a, 1);
        chk("t2_no_done", done_a, 0);
        tick();                                   // T+4
        chk("t2_done", done_a, 1);
        chk("t2_vout", vout_a, 64'h0000BBBB_0000AAAA);
        tick();
        chk("t2_done_off", done_a, 0);

        // Test 4: start pulses in ISSUE and DRAIN are ignored
        dc0 = done_cnt_a; ec0 = en_cnt_a;
        start_a = 1; wr_a = 0; base_a = 32'h10; stride_a = 1;
        tick();                                   // T+1, ISSUE
        tick();                                   // T+2
        start_a = 0;
        tick();                                   // T+3, DRAIN
        start_a = 1;
        tick();                                   // T+4, DONE
        start_a = 0;
        chk("t4_done", done_a, 1);
        repeat (4) tick();
        chk("t4_done_cnt", done_cnt_a - dc0, 1);
        chk("t4_en_cnt",   en_cnt_a - ec0, 2);
        chk("t4_idle",     busy_a, 0);

        // A store leaves vec_data_out untouched
        start_a = 1; wr_a = 1; base_a = 32'h40; vin_a = {32'h2, 32'h1};
        tick();
        start_a = 0;
        repeat (4) tick();
        chk("st_keep_vout", vout_a, 64'h0000BBBB_0000AAAA);
        chk("st_ram41", ram_a[8'h41], 32'h2);

        // Test 5: reset during load lane 1
        start_a = 1; wr_a = 0; base_a = 32'h10; stride_a = 1;
        tick();                                   // T+1
        start_a = 0;
        tick();                                   // T+2, lane 1
        rst_n = 1'b0;
        dc0 = done_cnt_a;
        tick();
        chk("t5_en",   en_a, 0);
        chk("t5_addr", addr_a, 0);
        chk("t5_wd",   wdata_a, 0);
        chk("t5_busy", busy_a, 0);
        chk("t5_done", done_a, 0);
        chk("t5_vout", vout_a, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t5_no_done", done_cnt_a - dc0, 0);
        start_a = 1; wr_a = 0; base_a = 32'h11; stride_a = 32'hFFFF_FFFF;
        tick();                                   // T+1
        start_a = 0;
        chk("t5_addr0", addr_a, 32'h11);
        tick();                                   // T+2
        chk("t5_addr1", addr_a, 32'h10);
        repeat (2) tick();                        // T+4
        chk("t5_done2", done_a, 1);
        chk("t5_vout2", vout_a, 64'h0000AAAA_0000BBBB);
        tick();

        // Test 3: B, strided load wrapping through zero
        start_b = 1; wr_b = 0; base_b = 32'hFFFF_FFF8; stride_b = 4;
        tick();                                   // T+1
        start_b = 0;
        chk("t3_addr0", addr_b, 32'hFFFF_FFF8);
        chk("t3_en0",   en_b, 1);
        tick();                                   // T+2
        chk("t3_addr1", addr_b, 32'hFFFF_FFFC);
        tick();                                   // T+3
        chk("t3_addr2", addr_b, 32'h0);
        tick();                                   // T+4
        chk("t3_addr3", addr_b, 32'h4);
        tick();                                   // T+5
        chk("t3_en_off", en_b, 0);
        repeat (2) tick();                        // T+7
        chk("t3_no_done", done_b, 0);
        tick();                                   // T+8
        chk("t3_done", done_b, 1);
        chk("t3_vout", vout_b, {32'hB000_0004, 32'hB000_0000, 32'hB000_00FC, 32'hB000_00F8});
        tick();
        chk("t3_idle", busy_b, 0);

        // Test 6: B, stride 0 broadcast load
        start_b = 1; wr_b = 0; base_b = 32'h20; stride_b = 0;
        tick();                                   // T+1
        start_b = 0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_addr%0d", i), {en_b, addr_b}, {1'b1, 32'h20});
            tick();
        end                                       // T+5
        repeat (3) tick();                        // T+8
        chk("t6_done", done_b, 1);
        chk("t6_vout", vout_b, {4{32'hB000_0020}});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
